// File: rtl/q_fixed_pkg.sv
// q_fixed_pkg: shared Q16.16 sign-magnitude definitions.
// Holds the format constants, the accumulator FSM state type and the
// sign-magnitude <-> two's-complement conversion helpers. The qmulti
// multiplier and its users import the same definitions.
package q_fixed_pkg;

  localparam int                Q_W       = 32;
  localparam int                Q_FRAC    = 16;
  localparam logic [Q_W-2:0]    Q_MAG_MAX = 31'h7FFFFFFF;
  localparam logic [Q_W-1:0]    Q_ONE     = 32'h00010000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } qstate_t;

  // Sign-magnitude to two's complement, one bit wider than the word so that
  // the full magnitude range converts without loss. Negative zero folds to 0.
  function automatic logic signed [Q_W:0] sm_to_tc(input logic [Q_W-1:0] sm);
    logic signed [Q_W:0] m;
    m = signed'({2'b00, sm[Q_W-2:0]});
    return (sm[Q_W-1] && (sm[Q_W-2:0] != '0)) ? -m : m;
  endfunction

  // Two's complement to sign-magnitude. The magnitude wraps to the low
  // Q_W-1 bits; a zero magnitude always carries a positive sign.
  function automatic logic [Q_W-1:0] tc_to_sm(input logic signed [63:0] v);
    logic [63:0]      a;
    logic [Q_W-2:0]   m;
    a = (v < 0) ? -v : v;
    m = a[Q_W-2:0];
    return {(v < 0) && (m != '0), m};
  endfunction

endpackage

// File: rtl/q_sm2tc.sv
// q_sm2tc: combinational Q16.16 sign-magnitude to ACC_W-bit two's-complement
// converter. Negative zero (0x80000000) converts to 0.
// Ports:
//   sm  in   32      sign-magnitude word (bit31 sign, bits30:0 magnitude)
//   tc  out  ACC_W   sign-extended two's-complement value
module q_sm2tc
  import q_fixed_pkg::*;
#(
  parameter int ACC_W = 35
) (
  input  logic [Q_W-1:0]          sm,
  output logic signed [ACC_W-1:0] tc
);

  assign tc = ACC_W'(sm_to_tc(sm));

endmodule

// File: rtl/qaccum.sv
// qaccum: frame accumulator for Q16.16 sign-magnitude products.
// A start pulse in IDLE opens a frame; N_TERMS products are accepted over a
// valid/ready handshake and summed in a wide signed accumulator; the sum is
// presented in sign-magnitude form until the consumer takes it.
// Build option: define QACCUM_SAT_EN to clamp an overflowing magnitude to
// 31'h7FFFFFFF; otherwise the magnitude wraps. overflow is reported either way.
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous active-high reset
//   start      in   1   opens a frame (IDLE only)
//   in_valid   in   1   in_data holds a product
//   in_ready   out  1   product accepted this cycle
//   in_data    in   32  Q16.16 sign-magnitude product
//   out_valid  out  1   out_data holds the frame sum
//   out_ready  in   1   consumer takes out_data
//   out_data   out  32  Q16.16 sign-magnitude sum
//   overflow   out  1   |sum| exceeded 31'h7FFFFFFF (valid with out_valid)
//   busy       out  1   frame in progress (ACC or DONE)
module qaccum
  import q_fixed_pkg::*;
#(
  parameter int N_TERMS = 8,
  parameter int CNT_W   = $clog2(N_TERMS) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        overflow,
  output logic        busy
);

  // Wide enough that N_TERMS full-scale products never wrap.
  localparam int ACC_W = Q_W + $clog2(N_TERMS);

  qstate_t                  state;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         cnt;

  logic signed [ACC_W-1:0]  term_tc;
  logic signed [ACC_W-1:0]  acc_next;
  logic [ACC_W-1:0]         acc_abs;
  logic                     ovf_next;
  logic [Q_W-1:0]           sm_wrap;
  logic [Q_W-1:0]           out_sm;
  logic                     xfer;
  logic                     last_term;

`ifdef QACCUM_SAT_EN
  function automatic logic [Q_W-1:0] saturate(input logic [Q_W-1:0] sm,
                                               input logic ovf);
    return ovf ? {sm[Q_W-1], Q_MAG_MAX} : sm;
  endfunction
`endif

  q_sm2tc #(
    .ACC_W (ACC_W)
  ) u_sm2tc (
    .sm (in_data),
    .tc (term_tc)
  );

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign xfer      = in_valid && in_ready;
  assign last_term = (cnt == CNT_W'(N_TERMS - 1));

  // Sum including the product on the input this cycle; the final one is
  // converted here so out_data is registered on the DONE entry edge.
  assign acc_next  = acc + term_tc;
  assign acc_abs   = (acc_next < 0) ? -acc_next : acc_next;
  assign ovf_next  = (acc_abs > {{(ACC_W-Q_W+1){1'b0}}, Q_MAG_MAX});
  assign sm_wrap   = tc_to_sm(64'(acc_next));

`ifdef QACCUM_SAT_EN
  assign out_sm = saturate(sm_wrap, ovf_next);
`else
  assign out_sm = sm_wrap;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        ACC: begin
          if (xfer) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (last_term) begin
              state    <= DONE;
              out_data <= out_sm;
              overflow <= ovf_next;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qaccum.sv
module tb_qaccum;

  typedef struct packed {
    logic [31:0] d;
    logic        o;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        overflow;
  logic        busy;

  exp_t        sb[$];
  int          n_vec;
  int          n_err;
  logic [31:0] v[8];

  qaccum #(.N_TERMS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got %h, want none", out_data);
        end else begin
          e = sb.pop_front();
          check("sum", out_data, e.d);
          check("overflow", {31'd0, overflow}, {31'd0, e.o});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        tick();
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Runs one frame from IDLE; entered and left at 1 time unit past an edge.
  task automatic run_frame(input logic [31:0] t[8], input logic [31:0] ed,
                           input logic eo, input bit gaps, input bit hold);
    sb.push_back('{d: ed, o: eo});
    if (hold) out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_acc", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) send(t[i], gaps);
    check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    check("done_in_ready", {31'd0, in_ready}, 32'd0);
    if (hold) begin
      for (int c = 0; c < 5; c++) begin
        start = 1'b1;
        check("hold_out_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", out_data, ed);
        check("hold_overflow", {31'd0, overflow}, {31'd0, eo});
        check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
      end
      out_ready = 1'b1;
      tick();
      start = 1'b0;
    end else begin
      tick();
    end
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 8 x 1.0 = 8.0
    v = '{default: 32'h00010000};
    run_frame(v, 32'h00080000, 1'b0, 1'b0, 1'b0);

    // 1.0 - 1.5 = -0.5
    v = '{32'h00010000, 32'h80018000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    run_frame(v, 32'h80008000, 1'b0, 1'b0, 1'b0);

    // 3 - 3 + (-0) = +0
    v = '{32'h00030000, 32'h80030000, 32'h80000000, 32'h0, 32'h0, 32'h0,
          32'h0, 32'h0};
    run_frame(v, 32'h00000000, 1'b0, 1'b0, 1'b0);

    // Full-scale positive and negative
    v = '{default: 32'h7FFFFFFF};
`ifdef QACCUM_SAT_EN
    run_frame(v, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0);
`else
    run_frame(v, 32'h7FFFFFF8, 1'b1, 1'b0, 1'b0);
`endif
    v = '{default: 32'hFFFFFFFF};
`ifdef QACCUM_SAT_EN
    run_frame(v, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
`else
    run_frame(v, 32'hFFFFFFF8, 1'b1, 1'b0, 1'b0);
`endif

    // Backpressure in DONE with start pulsed: 4 x 2.0 - 4 x 0.5 = 6.0
    v = '{32'h00020000, 32'h00020000, 32'h00020000, 32'h00020000,
          32'h80008000, 32'h80008000, 32'h80008000, 32'h80008000};
    run_frame(v, 32'h00060000, 1'b0, 1'b1, 1'b1);

    // in_valid gaps in ACC: 4 x (1.0 - 2.0) = -4.0
    v = '{32'h00010000, 32'h80020000, 32'h00010000, 32'h80020000,
          32'h00010000, 32'h80020000, 32'h00010000, 32'h80020000};
    run_frame(v, 32'h80040000, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-frame discards the partial sum
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h00010000, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    check("midrst_overflow", {31'd0, overflow}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("postrst_busy", {31'd0, busy}, 32'd0);

    // 8 x 0.5 = 4.0
    v = '{default: 32'h00008000};
    run_frame(v, 32'h00040000, 1'b0, 1'b0, 1'b0);

    tick();
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
